// File: rtl/imem_resp.sv
// imem_resp: word-addressed instruction memory with a registered read port,
// a byte-lane loader write port and a self-clearing start-up sequence.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_INIT  | clearing one word per cycle at clr_cnt; reads fault, loader blocked
// ST_SERVE | normal operation; reads return memory, loader writes accepted
module imem_resp #(
  parameter int                   BUS_WIDTH  = 32,
  parameter int                   AD_LEN     = 32,
  parameter int                   DEPTH      = 256,
  parameter logic [BUS_WIDTH-1:0] FAULT_WORD = 32'hFFFF_FFFF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [AD_LEN-1:0]    bus_ad_i,
  output logic [BUS_WIDTH-1:0] bus_data_o,
  output logic                 bus_err_o,
  input  logic                 ld_valid_i,
  input  logic [AD_LEN-1:0]    ld_addr_i,
  input  logic [31:0]          ld_data_i,
  input  logic [3:0]           ld_be_i,
  output logic                 ld_ready_o,
  output logic                 init_done_o
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(DEPTH - 1);

  logic [0:0]           state;
  logic [IDX_W-1:0]     clr_cnt;
  logic [BUS_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic             rd_oob;
  logic             rd_fault;
  logic [IDX_W-1:0] ld_idx;
  logic             ld_oob;
  logic             ld_accept;
  logic             unused_ld_lsb;

  // Address decode for both ports; anything above the top word is out of range.
  assign rd_idx    = bus_ad_i[IDX_W+1:2];
  assign rd_oob    = |bus_ad_i[AD_LEN-1:IDX_W+2];
  assign rd_fault  = (bus_ad_i[1:0] != 2'b00) || rd_oob || (state == ST_INIT);
  assign ld_idx    = ld_addr_i[IDX_W+1:2];
  assign ld_oob    = |ld_addr_i[AD_LEN-1:IDX_W+2];
  assign ld_ready_o = (state == ST_SERVE);
  assign ld_accept = ld_valid_i && ld_ready_o;

  // Loader writes are word-aligned; the low address bits carry no meaning.
  assign unused_ld_lsb = ^ld_addr_i[1:0];

  // Sequencer: clear every word once after reset, then serve until the next reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= ST_INIT;
      clr_cnt     <= '0;
      init_done_o <= 1'b0;
    end else begin
      init_done_o <= init_done_o || (state == ST_SERVE);
      case (state)
        ST_INIT: begin
          if (clr_cnt == CLR_LAST) begin
            state <= ST_SERVE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ST_SERVE;
      endcase
    end
  end

  // Memory array: zero fill during clear, byte-lane loader writes while serving.
  always_ff @(posedge clk_i) begin
    if (state == ST_INIT) begin
      mem[clr_cnt] <= '0;
    end else if (ld_accept && !ld_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (ld_be_i[b]) begin
          mem[ld_idx][8*b +: 8] <= ld_data_i[8*b +: 8];
        end
      end
    end
  end

  // Registered read port; a same-cycle write is not forwarded, so reads see old data.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bus_data_o <= FAULT_WORD;
      bus_err_o  <= 1'b1;
    end else if (rd_fault) begin
      bus_data_o <= FAULT_WORD;
      bus_err_o  <= 1'b1;
    end else begin
      bus_data_o <= mem[rd_idx];
      bus_err_o  <= 1'b0;
    end
  end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter BUS_WIDTH, default 32, SHALL set the read data width; only 32 is supported.
REQ-002 Parameter AD_LEN, default 32, SHALL set the bus address width.
REQ-003 Parameter DEPTH, default 256, SHALL set the number of 32-bit words; it must be a power of two, at least 4.
REQ-004 Parameter FAULT_WORD, default 32'hFFFF_FFFF, SHALL set the data returned on a faulting or not-ready read.
REQ-005 Port clk_i, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-006 Port reset_i, input, 1: reset, synchronous and active-high.
REQ-007 Port bus_ad_i, input, AD_LEN: byte address driven by the fetch initiator.
REQ-008 Port bus_data_o, output, BUS_WIDTH: registered read data.
REQ-009 Port bus_err_o, output, 1: registered fault flag that is time-aligned with bus_data_o.
REQ-010 Port ld_valid_i, input, 1: loader write request.
REQ-011 Port ld_addr_i, input, AD_LEN: loader byte address.
REQ-012 Port ld_data_i, input, 32: loader write data.
REQ-013 Port ld_be_i, input, 4: loader byte enables; bit n enables byte lane n (little-endian).
REQ-014 Port ld_ready_o, output, 1: the loader port accepts a write this cycle.
REQ-015 Port init_done_o, output, 1: memory clear has completed.

Function
REQ-016 The block SHALL implement a two-state FSM: INIT and SERVE.
REQ-017 INIT SHALL write 0 to one word per cycle, at index clr_cnt, starting from 0.
REQ-018 The FSM SHALL move from INIT to SERVE on the cycle the word at DEPTH-1 is written, so INIT lasts exactly DEPTH cycles.
REQ-019 SERVE SHALL be held until the next reset.
REQ-020 Read path, every cycle: the block SHALL register bus_data_o and bus_err_o from the current bus_ad_i, giving one-cycle latency.
REQ-021 Data for the address present before edge k SHALL be visible after edge k.
REQ-022 An initiator that drives the address, waits one cycle, then samples SHALL therefore capture the correct word.
REQ-023 The word index SHALL be bus_ad_i[log2(DEPTH)+1:2].
REQ-024 A read SHALL fault if any of the following holds:
- bus_ad_i[1:0] is not 0;
- bus_ad_i >= 4*DEPTH;
- the FSM is in INIT.
REQ-025 On a faulting read, bus_data_o SHALL be FAULT_WORD and bus_err_o SHALL be 1.
REQ-026 On a non-faulting read, bus_data_o SHALL be mem[index] and bus_err_o SHALL be 0.
REQ-027 ld_ready_o SHALL equal 1 exactly when the FSM is in SERVE; it is combinational from the state.
REQ-028 A loader write SHALL be accepted when ld_valid_i and ld_ready_o are both 1 at a rising edge.
REQ-029 An accepted write SHALL update only the byte lanes enabled by ld_be_i, at index ld_addr_i[log2(DEPTH)+1:2].
REQ-030 ld_addr_i[1:0] SHALL be ignored.
REQ-031 A write whose ld_addr_i >= 4*DEPTH SHALL be accepted and discarded.
REQ-032 A write with ld_be_i = 0 SHALL be accepted and SHALL have no effect.
REQ-033 If a read and an accepted write hit the same index in the same cycle, the read SHALL return the old contents; the new value is visible from the next read.
REQ-034 ld_valid_i asserted during INIT SHALL be ignored, with no write and no side effect.
REQ-035 Indices SHALL wrap-free: clr_cnt is log2(DEPTH) bits wide and does not advance once in SERVE.

Reset
REQ-036 While reset_i is 1 at a rising edge, the block SHALL set:
- state to INIT;
- clr_cnt to 0;
- bus_data_o to FAULT_WORD;
- bus_err_o to 1;
- init_done_o to 0;
- ld_ready_o to 0.
REQ-037 Reset asserted mid-clear or mid-serve SHALL restart the full INIT sequence.
REQ-038 Memory contents after a reset SHALL be all zero once init_done_o rises.
REQ-039 init_done_o SHALL be registered.
REQ-040 init_done_o SHALL rise on the first edge at which the state is SERVE and SHALL stay at 1 until reset.

Verification
REQ-041 The bench SHALL cover: reset for 2 cycles, release, hold bus_ad_i = 0 -> bus_err_o = 1 and bus_data_o = FFFF_FFFF for DEPTH cycles, then init_done_o = 1, ld_ready_o = 1, bus_data_o = 0, bus_err_o = 0.
REQ-042 The bench SHALL cover: after init, write 0xDEADBEEF at ld_addr 0x10 with be = 4'hF, then drive bus_ad_i = 0x10 -> bus_data_o = 0xDEADBEEF one cycle after the address is applied.
REQ-043 The bench SHALL cover: write 0x11223344 with be = 4'b0101 over the DEADBEEF word -> a read returns 0xDE22BE44.
REQ-044 The bench SHALL cover: read and write at index 4 in the same cycle with data 0xA5A5A5A5 -> that read returns the old value and the next read returns 0xA5A5A5A5.
REQ-045 The bench SHALL cover: bus_ad_i = 0x12, then bus_ad_i = 4*DEPTH -> bus_err_o = 1 and bus_data_o = FFFF_FFFF for each.
REQ-046 The bench SHALL cover a fetch-unit pairing: connect the fetch unit, preload words 0x00000013 and 0x00100093 at 0x0 and 0x4, and hold consume high then low each handshake -> the instructions are delivered in order and bus_err_o is never 1.
